// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: datapath width, register constants, ALU encodings and
// the stage-control field layout that decode and execute both rely on.
package rv32_pkg;
    localparam int         XLEN     = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10,
        ALU_PASS = 4'd11
    } alu_op_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       is_compressed;
        logic [3:0] alu_op;
    } stage_ctrl_t;

    // Write-back targets this source register (x0 never forwards).
    function automatic logic wb_hit(input logic we, input logic [4:0] wb_rd, input logic [4:0] rs);
        return we && (wb_rd != REG_ZERO) && (wb_rd == rs);
    endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// Decode -> ID/EX -> execute bus. master: decode/execute side; slave: the ID/EX register.
interface id_ex_stage_if #(
    parameter int XLEN = rv32_pkg::XLEN
);
    import rv32_pkg::*;

    logic            id_valid;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic            id_rs2_used;
    logic            id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_is_compressed;
    logic [3:0]      id_alu_op;

    logic            IDEX_valid;
    logic [XLEN-1:0] IDEX_pc, IDEX_rs1_data, IDEX_rs2_data, IDEX_imm;
    logic [4:0]      IDEX_IW_out_rs1, IDEX_IW_out_rs2, IDEX_IW_out_rd;
    logic            IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite_out, IDEX_MemToReg, IDEX_alu_src, IDEX_is_compressed;
    logic [3:0]      IDEX_alu_op;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, id_rs2_used,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_is_compressed, id_alu_op,
        input  IDEX_valid, IDEX_pc, IDEX_rs1_data, IDEX_rs2_data, IDEX_imm,
               IDEX_IW_out_rs1, IDEX_IW_out_rs2, IDEX_IW_out_rd,
               IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite_out, IDEX_MemToReg, IDEX_alu_src,
               IDEX_is_compressed, IDEX_alu_op
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, id_rs2_used,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_is_compressed, id_alu_op,
        output IDEX_valid, IDEX_pc, IDEX_rs1_data, IDEX_rs2_data, IDEX_imm,
               IDEX_IW_out_rs1, IDEX_IW_out_rs2, IDEX_IW_out_rd,
               IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite_out, IDEX_MemToReg, IDEX_alu_src,
               IDEX_is_compressed, IDEX_alu_op
    );
endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard term; only built when ID_EX_LOAD_USE_DETECT_EN is defined.
`ifdef ID_EX_LOAD_USE_DETECT_EN
module load_use_detect
    import rv32_pkg::*;
(
    input  logic       idex_valid,
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs2_used,
    output logic       hazard
);
    assign hazard = idex_valid && idex_mem_read && (idex_rd != REG_ZERO) && id_valid &&
                    ((idex_rd == id_rs1) || (id_rs2_used && (idex_rd == id_rs2)));
endmodule
`endif

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: bubbles on flush and load-use, holds on stall, WB write-through.
// Load-use detection and bubble_count are built only with `define ID_EX_LOAD_USE_DETECT_EN.
module id_ex_stage #(
    parameter int XLEN  = rv32_pkg::XLEN,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             MEMWB_RegWrite_out,
    input  logic [4:0]       MEMWB_RD,
    input  logic [XLEN-1:0]  wb_data,
    output logic             ifid_write_en,
    output logic             pc_write_en,
    output logic [CNT_W-1:0] bubble_count,
    id_ex_stage_if.slave     bus
);
    import rv32_pkg::*;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        stage_ctrl_t     ctrl;
    } idex_t;

    idex_t q, cap;
    logic  hazard;

`ifdef ID_EX_LOAD_USE_DETECT_EN
    load_use_detect u_lud (
        .idex_valid    (q.valid),
        .idex_mem_read (q.ctrl.mem_read),
        .idex_rd       (q.rd),
        .id_valid      (bus.id_valid),
        .id_rs1        (bus.id_rs1),
        .id_rs2        (bus.id_rs2),
        .id_rs2_used   (bus.id_rs2_used),
        .hazard        (hazard)
    );

    // Only hazard bubbles count; flush and hold take precedence over the hazard.
    always_ff @(posedge clk) begin
        if (!rst_n)
            bubble_count <= '0;
        else if (!flush_i && !stall_i && hazard && (bubble_count != '1))
            bubble_count <= bubble_count + CNT_W'(1);
    end
`else
    assign hazard       = 1'b0;
    assign bubble_count = '0;
`endif

    always_comb begin
        cap                    = '0;
        cap.valid              = bus.id_valid;
        cap.pc                 = bus.id_pc;
        cap.imm                = bus.id_imm;
        cap.rs1                = bus.id_rs1;
        cap.rs2                = bus.id_rs2;
        cap.rd                 = bus.id_rd;
        cap.ctrl.reg_write     = bus.id_reg_write;
        cap.ctrl.mem_read      = bus.id_mem_read;
        cap.ctrl.mem_write     = bus.id_mem_write;
        cap.ctrl.mem_to_reg    = bus.id_mem_to_reg;
        cap.ctrl.alu_src       = bus.id_alu_src;
        cap.ctrl.is_compressed = bus.id_is_compressed;
        cap.ctrl.alu_op        = bus.id_alu_op;
        cap.rs1_data = wb_hit(MEMWB_RegWrite_out, MEMWB_RD, bus.id_rs1) ? wb_data : bus.id_rs1_data;
        cap.rs2_data = wb_hit(MEMWB_RegWrite_out, MEMWB_RD, bus.id_rs2) ? wb_data : bus.id_rs2_data;
    end

    // Priority: reset, flush, hold, hazard bubble, capture.
    always_ff @(posedge clk) begin
        if (!rst_n)
            q <= '0;
        else if (flush_i)
            q <= '0;
        else if (!stall_i)
            q <= hazard ? '0 : cap;
    end

    assign ifid_write_en = rst_n && (flush_i || (!stall_i && !hazard));
    assign pc_write_en   = ifid_write_en;

    assign bus.IDEX_valid         = q.valid;
    assign bus.IDEX_pc            = q.pc;
    assign bus.IDEX_rs1_data      = q.rs1_data;
    assign bus.IDEX_rs2_data      = q.rs2_data;
    assign bus.IDEX_imm           = q.imm;
    assign bus.IDEX_IW_out_rs1    = q.rs1;
    assign bus.IDEX_IW_out_rs2    = q.rs2;
    assign bus.IDEX_IW_out_rd     = q.rd;
    assign bus.IDEX_RegWrite      = q.ctrl.reg_write;
    assign bus.IDEX_MemRead       = q.ctrl.mem_read;
    assign bus.IDEX_MemWrite_out  = q.ctrl.mem_write;
    assign bus.IDEX_MemToReg      = q.ctrl.mem_to_reg;
    assign bus.IDEX_alu_src       = q.ctrl.alu_src;
    assign bus.IDEX_is_compressed = q.ctrl.is_compressed;
    assign bus.IDEX_alu_op        = q.ctrl.alu_op;
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the RV32IC core. It captures decoded operands and control from the decode stage and presents them to the execute stage and the forwarding unit as the IDEX_* signals. It inserts bubbles on load-use hazards and on branch flush, holds on external stall, and performs write-back write-through on captured register operands.

## Interface
Parameters:
- XLEN, 32, datapath width.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, active-low; one clock, synchronous, active-low reset.
- stall_i  in  1  external hold (memory busy).
- flush_i  in  1  branch/jump taken in EX; kill the instruction being captured.
- id_valid  in  1  decode stage holds a valid instruction.
- id_pc  in  XLEN  instruction PC.
- id_rs1, id_rs2, id_rd  in  5  register indices.
- id_rs2_used  in  1  instruction reads rs2.
- id_rs1_data, id_rs2_data, id_imm  in  XLEN  register file reads and immediate.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_is_compressed  in  1  control.
- id_alu_op  in  4  ALU operation.
- MEMWB_RegWrite_out  in  1  write-back write enable.
- MEMWB_RD  in  5  write-back destination.
- wb_data  in  XLEN  write-back value.
- IDEX_valid  out  1  stage holds a real instruction.
- IDEX_pc, IDEX_rs1_data, IDEX_rs2_data, IDEX_imm  out  XLEN.
- IDEX_IW_out_rs1, IDEX_IW_out_rs2, IDEX_IW_out_rd  out  5.
- IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite_out, IDEX_MemToReg, IDEX_alu_src, IDEX_is_compressed  out  1.
- IDEX_alu_op  out  4.
- ifid_write_en, pc_write_en  out  1  combinational; low means IF/ID and PC hold.
- bubble_count  out  CNT_W  saturating count of inserted bubbles.

## Operation
- Per-cycle action, in priority order: reset, then flush, then hold, then bubble, then capture.
  - Reset: all registered outputs 0. bubble_count = 0.
  - Flush (flush_i=1): load a bubble. Flush overrides stall_i and hazard.
  - Hold (stall_i=1): all IDEX registers keep their values.
  - Bubble (load-use hazard detected): load a bubble.
  - Capture: load all id_* fields. IDEX_valid = id_valid.
- A bubble sets every IDEX output to 0, including the rd, rs1 and rs2 indices, so downstream index comparisons cannot match.
- Load-use hazard is raised when all of the following hold:
  - IDEX_valid and IDEX_MemRead are 1.
  - IDEX_IW_out_rd is not 0.
  - id_valid is 1.
  - IDEX_IW_out_rd equals id_rs1, or equals id_rs2 while id_rs2_used is 1.
- Write-through at capture:
  - If MEMWB_RegWrite_out=1, MEMWB_RD≠0 and MEMWB_RD==id_rs1, IDEX_rs1_data takes wb_data. Same rule for rs2.
  - Write-through is not applied to bubble or hold cycles.
- ifid_write_en and pc_write_en:
  - 0 when rst_n=0.
  - 0 when stall_i=1 and flush_i=0.
  - 0 when a hazard is detected and neither flush_i nor stall_i is set.
  - 1 otherwise.
- bubble_count increments by 1 on each hazard bubble only; flush bubbles are not counted. It saturates at all-ones.

## Timing
- Capture latency is 1 cycle: id_* at edge N appears on IDEX_* after edge N.
- A load-use hazard costs exactly 1 bubble. After the bubble, IDEX_MemRead=0, so the hazard clears and the held instruction is captured on the next edge.
- stall_i and hazard together: hold wins. The load stays in IDEX and the hazard is re-evaluated once stall_i drops.
- flush_i, stall_i and hazard together: bubble, with ifid_write_en=1 and pc_write_en=1.
- rst_n deasserted mid-stall: the first edge with rst_n=1 performs a normal priority evaluation starting from the all-zero state.

## Configuration
- ID_EX_LOAD_USE_DETECT_EN defined: hazard detection, hazard bubbles and bubble_count are active as described.
- Macro undefined: the hazard term is constant 0 and bubble_count is tied to 0. Flush, hold and write-through are unchanged. Load-use interlocking must then come from stall_i.

## Structure
- Shared package rv32_pkg holds:
  - XLEN.
  - Constant REG_ZERO = 5'd0.
  - ALU-op encodings (4-bit).
  - The stage-control field layout, so decode and execute agree.
- Sub-module load_use_detect: combinational hazard term, compiled only when ID_EX_LOAD_USE_DETECT_EN is defined.
- Everything else is in id_ex_stage.

## Test plan
- Reset check: rst_n=0 for 2 cycles with random id_* inputs → all IDEX_* = 0, ifid_write_en=0, bubble_count=0.
- Load-use on rs2: IDEX holds lw x5 (MemRead=1, rd=5), decode presents add x6,x1,x5 with id_rs2_used=1 → next edge is a bubble (IDEX_valid=0, rd=0), ifid_write_en=0 for 1 cycle, add captured on the following edge, bubble_count=1.
- Flush priority: flush_i=1, stall_i=1, hazard present → IDEX_valid=0, ifid_write_en=1, bubble_count unchanged.
- Write-through: id_rs1=7, id_rs1_data=0x11, MEMWB_RegWrite_out=1, MEMWB_RD=7, wb_data=0xDEADBEEF → IDEX_rs1_data=0xDEADBEEF. Repeat with MEMWB_RD=0 → IDEX_rs1_data=0x11.
- Hold: stall_i=1 for 3 cycles while id_* changes → IDEX_* unchanged for all 3 cycles, pc_write_en=0.
- Saturation (CNT_W=4): 20 back-to-back load-use pairs → bubble_count stops at 15.
